// File: rtl/pw_entry_controller.sv
// ----------------------------------------------------------------------------
// Module : pw_entry_controller
// Collects PW_LEN button presses, compares them with PASSWORD, and tracks
// failures with a timed lockout. Optional macro PW_LOCK_ESCALATE_EN doubles
// the lockout time on each successive lockout.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pw_entry_controller #(
  parameter int unsigned          PW_LEN         = 4,
  parameter logic [2*PW_LEN-1:0]  PASSWORD       = 8'b00_01_10_11,
  parameter int unsigned          MAX_TRIES      = 3,
  parameter int unsigned          HOLD_CYCLES    = 100_000_000,
  parameter int unsigned          LOCK_CYCLES    = 500_000_000,
  parameter int unsigned          TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [4:0] out_char,
  output logic       unlocked,
  output logic       locked,
  output logic [2:0] fail_cnt,
  output logic [3:0] led
);

  localparam int BW = 2 * PW_LEN;
`ifdef PW_LOCK_ESCALATE_EN
  localparam longint unsigned LOCK_MAX = 64'(LOCK_CYCLES) << 3;
`else
  localparam longint unsigned LOCK_MAX = 64'(LOCK_CYCLES);
`endif
  localparam longint unsigned DW_A   = (64'(HOLD_CYCLES) > 64'(TIMEOUT_CYCLES)) ?
                                       64'(HOLD_CYCLES) : 64'(TIMEOUT_CYCLES);
  localparam longint unsigned DW_MAX = (DW_A > LOCK_MAX) ? DW_A : LOCK_MAX;
  localparam int              CNT_W  = $clog2(DW_MAX + 64'd1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_CHECK  = 3'd2,
    S_OPEN   = 3'd3,
    S_FAIL   = 3'd4,
    S_LOCKED = 3'd5
  } state_t;

  state_t           state_q;
  logic [3:0]       btn_q;
  logic [BW-1:0]    buf_q;
  logic [3:0]       count_q;
  logic             inv_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       out_char_q;
  logic             unlocked_q;
  logic             locked_q;
  logic [2:0]       fail_cnt_q;
  logic [3:0]       led_q;

  logic [3:0]       btn_edge;
  logic             press;
  logic             multi;
  logic [1:0]       code;
  logic [3:0]       count_d;
  logic [CNT_W-1:0] lock_last;

  assign btn_edge = btn & ~btn_q;
  assign press    = |btn_edge;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi    = |(btn_edge & (btn_edge - 4'd1));
  assign count_d  = (state_q == S_IDLE) ? 4'd1 : count_q + 4'd1;

  always_comb begin
    code = 2'd0;
    if (btn_edge[3])      code = 2'd3;
    else if (btn_edge[2]) code = 2'd2;
    else if (btn_edge[1]) code = 2'd1;
  end

`ifdef PW_LOCK_ESCALATE_EN
  logic [1:0] esc_q;
  logic [1:0] lock_sh_q;
  assign lock_last = (CNT_W'(LOCK_CYCLES) << lock_sh_q) - CNT_W'(1);
`else
  assign lock_last = CNT_W'(LOCK_CYCLES - 1);
`endif

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      btn_q      <= 4'hF;
      buf_q      <= '0;
      count_q    <= 4'd0;
      inv_q      <= 1'b0;
      cnt_q      <= '0;
      out_char_q <= 5'd0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
      fail_cnt_q <= 3'd0;
      led_q      <= 4'd0;
`ifdef PW_LOCK_ESCALATE_EN
      esc_q      <= 2'd0;
      lock_sh_q  <= 2'd0;
`endif
    end else begin
      btn_q <= btn;
      cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        S_IDLE, S_ENTRY: begin
          if (press) begin
            buf_q      <= (state_q == S_IDLE) ? BW'(code) : BW'({buf_q, code});
            inv_q      <= ((state_q == S_ENTRY) && inv_q) || multi;
            count_q    <= count_d;
            out_char_q <= 5'(count_d);
            led_q      <= 4'd1 << code;
            cnt_q      <= '0;
            state_q    <= (count_d == 4'(PW_LEN)) ? S_CHECK : S_ENTRY;
          end else if (state_q == S_ENTRY && cnt_q == TIMEOUT_LAST) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            count_q    <= 4'd0;
            inv_q      <= 1'b0;
            out_char_q <= 5'd0;
            led_q      <= 4'd0;
            cnt_q      <= '0;
          end
        end
        S_CHECK: begin
          cnt_q <= '0;
          led_q <= 4'd0;
          if (buf_q == PASSWORD && !inv_q) begin
            state_q    <= S_OPEN;
            unlocked_q <= 1'b1;
            out_char_q <= 5'd16;
            fail_cnt_q <= 3'd0;
`ifdef PW_LOCK_ESCALATE_EN
            esc_q      <= 2'd0;
`endif
          end else begin
            state_q    <= S_FAIL;
            out_char_q <= 5'd17;
            fail_cnt_q <= (fail_cnt_q == 3'd7) ? 3'd7 : fail_cnt_q + 3'd1;
          end
        end
        S_OPEN: begin
          if (cnt_q == HOLD_LAST) begin
            state_q    <= S_IDLE;
            unlocked_q <= 1'b0;
            out_char_q <= 5'd0;
            buf_q      <= '0;
            count_q    <= 4'd0;
            inv_q      <= 1'b0;
            cnt_q      <= '0;
          end
        end
        S_FAIL: begin
          if (cnt_q == HOLD_LAST) begin
            buf_q   <= '0;
            count_q <= 4'd0;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
            if (fail_cnt_q >= 3'(MAX_TRIES)) begin
              state_q    <= S_LOCKED;
              locked_q   <= 1'b1;
              out_char_q <= 5'd18;
`ifdef PW_LOCK_ESCALATE_EN
              lock_sh_q  <= esc_q;
              esc_q      <= (esc_q == 2'd3) ? 2'd3 : esc_q + 2'd1;
`endif
            end else begin
              state_q    <= S_IDLE;
              out_char_q <= 5'd0;
            end
          end
        end
        S_LOCKED: begin
          if (cnt_q == lock_last) begin
            state_q    <= S_IDLE;
            locked_q   <= 1'b0;
            out_char_q <= 5'd0;
            fail_cnt_q <= 3'd0;
            cnt_q      <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out_char = out_char_q;
  assign unlocked = unlocked_q;
  assign locked   = locked_q;
  assign fail_cnt = fail_cnt_q;
  assign led      = led_q;

endmodule

`default_nettype wire

// File: tb/tb_pw_entry_controller.sv
// ----------------------------------------------------------------------------
// Module : tb_pw_entry_controller
// Directed self-checking bench for pw_entry_controller with short dwell times.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pw_entry_controller;

  localparam int HOLD    = 8;
  localparam int LOCK    = 16;
  localparam int TIMEOUT = 32;
`ifdef PW_LOCK_ESCALATE_EN
  localparam int LOCK2 = 32;
`else
  localparam int LOCK2 = 16;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic [4:0] out_char;
  logic       unlocked;
  logic       locked;
  logic [2:0] fail_cnt;
  logic [3:0] led;

  int n_checks = 0;
  int n_errors = 0;

  pw_entry_controller #(
    .HOLD_CYCLES   (HOLD),
    .LOCK_CYCLES   (LOCK),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clkin   (clk),
    .reset   (rst_n),
    .btn     (btn),
    .out_char(out_char),
    .unlocked(unlocked),
    .locked  (locked),
    .fail_cnt(fail_cnt),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    btn = 4'(1 << b);
    tick();
    btn = 4'd0;
  endtask

  // Four presses spaced 4 clocks apart; returns just after the CHECK entry edge.
  task automatic enter4(input int a, input int b, input int c, input int d);
    press(a); repeat (3) tick();
    press(b); repeat (3) tick();
    press(c); repeat (3) tick();
    press(d);
  endtask

  task automatic fail_attempt(input int exp_fail);
    enter4(0, 1, 3, 2);
    tick();
    check("fail_char", out_char, 17);
    check("fail_cnt", fail_cnt, exp_fail);
    repeat (HOLD) tick();
  endtask

  initial begin
    btn   = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_char", out_char, 0);
    check("rst_unlocked", unlocked, 0);
    check("rst_locked", locked, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_led", led, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Correct code
    press(0); check("s1_c1", out_char, 1); check("s1_led1", led, 4'b0001);
    repeat (3) tick();
    press(1); check("s1_c2", out_char, 2); check("s1_led2", led, 4'b0010);
    repeat (3) tick();
    press(2); check("s1_c3", out_char, 3);
    repeat (3) tick();
    press(3); check("s1_check_char", out_char, 4); check("s1_check_unl", unlocked, 0);
    tick();
    check("s1_unlocked", unlocked, 1);
    check("s1_open_char", out_char, 16);
    check("s1_fail", fail_cnt, 0);
    repeat (HOLD - 1) tick();
    check("s1_open_last", unlocked, 1);
    tick();
    check("s1_idle_unl", unlocked, 0);
    check("s1_idle_char", out_char, 0);

    // Wrong code, press during FAIL dropped
    enter4(0, 1, 3, 2);
    check("s2_check_char", out_char, 4);
    tick();
    check("s2_fail_char", out_char, 17);
    check("s2_fail_cnt", fail_cnt, 1);
    press(0);
    check("s2_drop_char", out_char, 17);
    repeat (HOLD - 2) tick();
    check("s2_fail_last", out_char, 17);
    tick();
    check("s2_idle_char", out_char, 0);
    check("s2_idle_fail", fail_cnt, 1);

    // Lockouts: first from fail_cnt 1, second from fail_cnt 0
    for (int k = 0; k < 2; k++) begin
      int lock_len;
      int first;
      lock_len = (k == 0) ? LOCK : LOCK2;
      first    = (k == 0) ? 2 : 1;
      for (int f = first; f < 3; f++) begin
        fail_attempt(f);
        check("s3_idle_char", out_char, 0);
        check("s3_not_locked", locked, 0);
      end
      fail_attempt(3);
      check("s3_locked", locked, 1);
      check("s3_lock_char", out_char, 18);
      repeat (lock_len - 1) tick();
      check("s3_lock_last", locked, 1);
      tick();
      check("s3_unlock", locked, 0);
      check("s3_idle_char2", out_char, 0);
      check("s3_fail_clr", fail_cnt, 0);
    end

    // Entry timeout then successful entry
    press(0);
    check("s4_c1", out_char, 1);
    repeat (TIMEOUT - 1) tick();
    check("s4_before_to", out_char, 1);
    tick();
    check("s4_to_char", out_char, 0);
    check("s4_to_led", led, 0);
    check("s4_to_fail", fail_cnt, 0);
    enter4(0, 1, 2, 3);
    tick();
    check("s4_open", unlocked, 1);
    repeat (HOLD) tick();
    check("s4_idle", unlocked, 0);

    // Multi-edge press invalidates attempt
    btn = 4'b0011;
    tick();
    btn = 4'd0;
    check("s5_c1", out_char, 1);
    repeat (3) tick();
    press(2); repeat (3) tick();
    press(3); repeat (3) tick();
    press(0);
    check("s5_count4", out_char, 4);
    tick();
    check("s5_fail_char", out_char, 17);
    check("s5_unlocked", unlocked, 0);
    check("s5_fail_cnt", fail_cnt, 1);

    // Button held through reset, then asynchronous reset mid-entry
    btn   = 4'b0001;
    rst_n = 1'b0;
    tick();
    check("s6_rst_char", out_char, 0);
    check("s6_rst_fail", fail_cnt, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("s6_held_char", out_char, 0);
    check("s6_held_led", led, 0);
    btn = 4'd0;
    tick();
    press(0);
    check("s6_c1", out_char, 1);
    check("s6_led", led, 4'b0001);
    repeat (3) tick();
    press(1);
    check("s6_c2", out_char, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_char", out_char, 0);
    check("s6_async_led", led, 0);
    check("s6_async_unl", unlocked, 0);
    check("s6_async_lock", locked, 0);
    check("s6_async_fail", fail_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
